// File: rtl/prga_fifo_cnt_if.sv
// Handshake bundle for prga_fifo_cnt: producer side (wr/din/full), consumer side (rd/dout/empty),
// plus occupancy and sticky error flags. slave = the FIFO, master = the attached logic.
interface prga_fifo_cnt_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  almost_empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, din, rd,
        input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, din, rd,
        output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/prga_fifo_cnt.sv
// Power-of-two synchronous FIFO with occupancy count, almost flags and registered or fall-through read.
// Define PRGA_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow registers; otherwise they read 0.
module prga_fifo_cnt #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2,
    parameter int LOOKAHEAD  = 0,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    prga_fifo_cnt_if.slave     f
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] AF_TH = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
    localparam logic [DEPTH_LOG2:0] AE_TH = (DEPTH_LOG2+1)'(AE_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr, occ;
    logic                  full_s, empty_s, wr_acc, rd_acc;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (all bits equal).
    assign occ     = wr_ptr - rd_ptr;
    assign full_s  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty_s = (wr_ptr == rd_ptr);
    assign wr_acc  = f.wr && !full_s;
    assign rd_acc  = f.rd && !empty_s;

    assign f.count        = occ;
    assign f.full         = full_s;
    assign f.empty        = empty_s;
    assign f.almost_full  = (occ >= AF_TH);
    assign f.almost_empty = (occ <= AE_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= f.din;
    end

    generate
        if (LOOKAHEAD != 0) begin : g_fwft
            assign f.dout = mem[rd_ptr[DEPTH_LOG2-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            assign f.dout = dout_q;
        end
    endgenerate

`ifdef PRGA_FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (f.wr && full_s)  ovf_q <= 1'b1;
            if (f.rd && empty_s) udf_q <= 1'b1;
        end
    end
    assign f.overflow  = ovf_q;
    assign f.underflow = udf_q;
`else
    assign f.overflow  = 1'b0;
    assign f.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_prga_fifo_cnt.sv
// Three FIFOs (registered, fall-through, altered thresholds) share one stimulus stream and are
// compared every cycle against a queue model, plus directed literal checks.
module tb_prga_fifo_cnt;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] din = 8'h00;
    int         tests = 0, fails = 0;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    prga_fifo_cnt_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) if0 ();
    prga_fifo_cnt_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) if1 ();
    prga_fifo_cnt_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) if2 ();

    assign if0.wr = wr; assign if0.rd = rd; assign if0.din = din;
    assign if1.wr = wr; assign if1.rd = rd; assign if1.din = din;
    assign if2.wr = wr; assign if2.rd = rd; assign if2.din = din;

    prga_fifo_cnt #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(0), .AF_MARGIN(1), .AE_MARGIN(1))
        u0 (.clk(clk), .rst_n(rst_n), .f(if0));
    prga_fifo_cnt #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(1), .AF_MARGIN(1), .AE_MARGIN(1))
        u1 (.clk(clk), .rst_n(rst_n), .f(if1));
    prga_fifo_cnt #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(0), .AF_MARGIN(2), .AE_MARGIN(0))
        u2 (.clk(clk), .rst_n(rst_n), .f(if2));

    // Reference model: contents are identical across instances since stimulus is shared.
    logic [7:0] q[$];
    logic [7:0] dm = 8'h00;
    bit         ovm = 1'b0, unm = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); dm = 8'h00; ovm = 1'b0; unm = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (q.size() == 4);
            was_empty = (q.size() == 0);
            if (wr && was_full)  ovm = 1'b1;
            if (rd && was_empty) unm = 1'b1;
            if (rd && !was_empty) dm = q.pop_front();
            if (wr && !was_full)  q.push_back(din);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string nm, int afm, int aem, bit la, logic [2:0] c, logic fu, logic af,
                       logic em, logic ae, logic [7:0] d, logic ov, logic un);
        int n;
        n = q.size();
        chk({nm, ".count"}, 32'(c), n);
        chk({nm, ".full"}, 32'(fu), 32'(n == 4));
        chk({nm, ".empty"}, 32'(em), 32'(n == 0));
        chk({nm, ".almost_full"}, 32'(af), 32'(n >= 4 - afm));
        chk({nm, ".almost_empty"}, 32'(ae), 32'(n <= aem));
        if (la) begin
            if (n > 0) chk({nm, ".dout"}, 32'(d), 32'(q[0]));
        end else begin
            chk({nm, ".dout"}, 32'(d), 32'(dm));
        end
`ifdef PRGA_FIFO_ERR_FLAGS_EN
        chk({nm, ".overflow"}, 32'(ov), 32'(ovm));
        chk({nm, ".underflow"}, 32'(un), 32'(unm));
`else
        chk({nm, ".overflow"}, 32'(ov), 32'd0);
        chk({nm, ".underflow"}, 32'(un), 32'd0);
`endif
    endtask

    always @(negedge clk) if (started) begin
        cmp("u0", 1, 1, 1'b0, if0.count, if0.full, if0.almost_full, if0.empty, if0.almost_empty,
            if0.dout, if0.overflow, if0.underflow);
        cmp("u1", 1, 1, 1'b1, if1.count, if1.full, if1.almost_full, if1.empty, if1.almost_empty,
            if1.dout, if1.overflow, if1.underflow);
        cmp("u2", 2, 0, 1'b0, if2.count, if2.full, if2.almost_full, if2.empty, if2.almost_empty,
            if2.dout, if2.overflow, if2.underflow);
    end

    // Apply inputs at a falling edge, then return at the next falling edge.
    task automatic step(bit w, bit r, logic [7:0] d);
        wr = w; rd = r; din = d;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst.empty", 32'(if0.empty), 1);
        chk("rst.count", 32'(if0.count), 0);
        chk("rst.dout", 32'(if0.dout), 0);
        chk("rst.af", 32'(if0.almost_full), 0);
        chk("rst.ae", 32'(if0.almost_empty), 1);
        chk("rst.ae_u2", 32'(if2.almost_empty), 1);
        rst_n = 1'b1;
        started = 1'b1;

        // Fill and overflow
        step(1, 0, 8'h11);
        chk("thr.ae_cnt1", 32'(if2.almost_empty), 0);
        chk("thr.af_cnt1", 32'(if2.almost_full), 0);
        step(1, 0, 8'h22);
        chk("thr.af_cnt2", 32'(if2.almost_full), 1);
        chk("fill.af_cnt2", 32'(if0.almost_full), 0);
        step(1, 0, 8'h33);
        chk("fill.af_cnt3", 32'(if0.almost_full), 1);
        chk("fill.count3", 32'(if0.count), 3);
        step(1, 0, 8'h44);
        chk("fill.full", 32'(if0.full), 1);
        chk("fill.count4", 32'(if0.count), 4);
        step(1, 0, 8'h55);
        chk("fill.count_after_drop", 32'(if0.count), 4);
`ifdef PRGA_FIFO_ERR_FLAGS_EN
        chk("fill.overflow", 32'(if0.overflow), 1);
`else
        chk("fill.overflow", 32'(if0.overflow), 0);
`endif
        chk("fwft.head", 32'(if1.dout), 8'h11);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 8'h00);
            chk("fill.read_dout", 32'(if0.dout), 32'(k * 8'h11));
        end
        chk("fill.drained", 32'(if0.empty), 1);

        // Fall-through
        step(1, 0, 8'hA5);
        chk("fwft.empty", 32'(if1.empty), 0);
        chk("fwft.dout", 32'(if1.dout), 8'hA5);
        step(0, 1, 8'h00);
        chk("fwft.empty_after_pop", 32'(if1.empty), 1);

        // rd && wr while full: only the read lands
        for (int k = 0; k < 4; k++) step(1, 0, 8'(k));
        step(1, 1, 8'hEE);
        chk("bnd.full_rdwr_count", 32'(if0.count), 3);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h00);
        chk("bnd.last_drain", 32'(if0.dout), 3);
        chk("bnd.ee_lost", 32'(if0.count), 0);

        // rd && wr while empty: only the write lands
        step(1, 1, 8'h5A);
        chk("bnd.empty_rdwr_count", 32'(if0.count), 1);
        chk("bnd.dout_held", 32'(if0.dout), 3);
        step(0, 1, 8'h00);
        chk("bnd.dout_5a", 32'(if0.dout), 8'h5A);

        // Wrap-around streaming at occupancy 2
        step(1, 0, 8'h00);
        step(1, 0, 8'h01);
        for (int j = 2; j <= 8'h13; j++) begin
            step(1, 1, 8'(j));
            chk("wrap.count", 32'(if0.count), 2);
            chk("wrap.dout", 32'(if0.dout), 32'(j - 2));
        end
        step(0, 1, 8'h00);
        chk("wrap.tail0", 32'(if0.dout), 8'h12);
        step(0, 1, 8'h00);
        chk("wrap.tail1", 32'(if0.dout), 8'h13);

        // Reset mid-stream
        step(1, 0, 8'h61); step(1, 0, 8'h62); step(1, 0, 8'h63);
        wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.empty", 32'(if0.empty), 1);
        chk("mrst.count", 32'(if0.count), 0);
        chk("mrst.dout", 32'(if0.dout), 0);
        chk("mrst.empty_u1", 32'(if1.empty), 1);
        chk("mrst.ovf", 32'(if0.overflow), 0);
        chk("mrst.udf", 32'(if0.underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h77);
        chk("mrst.fwft_new", 32'(if1.dout), 8'h77);
        step(0, 1, 8'h00);
        chk("mrst.first_post", 32'(if0.dout), 8'h77);

        // Randomized traffic with shifting write/read bias to visit full and empty
        for (int ph = 0; ph < 6; ph++) begin
            int wp, rp;
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 50;
            rp = 100 - wp;
            for (int i = 0; i < 300; i++)
                step($urandom_range(99) < wp, $urandom_range(99) < rp, 8'($urandom));
        end
        step(0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
